tl_channel_buffer: RTL
======================

// Module: tl_channel_buffer
// PURPOSE
//   Parametrised TileLink-C buffer on the A, C, D and E channels, placed between two diplomatic nodes.
//   Each channel has its own depth. Depth 0 is a pure wire; depth >= 1 is a registered queue.
//   Per-channel FLOW (empty bypass) and PIPE (ready-through when full) modes are available.
//   An idle flag reports when all queues are empty, for clock gating or flush checks.
// PARAMETERS
//   ADDR_W     32  address width (A and C channels)
//   DATA_W     64  data width; mask width is DATA_W/8
//   SIZE_W      3  size field width
//   SOURCE_W    3  source id width
//   SINK_W      3  sink id width
//   A_DEPTH     2  A queue entries (0 = wire)
//   C_DEPTH     2  C queue entries (0 = wire)
//   D_DEPTH     2  D queue entries (0 = wire)
//   E_DEPTH     0  E queue entries (0 = wire)
//   FLOW_MASK   0  bit per channel {E,D,C,A}: 1 = empty-queue combinational bypass
//   PIPE_MASK   0  bit per channel {E,D,C,A}: 1 = enq ready when full and deq ready
// PORTS
//   clock          in   1      single clock
//   reset          in   1      synchronous, active-low
//   in_a_valid     in   1      A request from master side
//   in_a_ready     out  1      A accept
//   in_a_bits      in   A_W    packed A {opcode,param,size,source,address,mask,data,corrupt}
//   out_a_valid    out  1      A toward slave
//   out_a_ready    in   1      slave accept
//   out_a_bits     out  A_W    packed A
//   in_c_valid/ready/bits  in/out/in    1/1/C_W  C from master; C omits mask
//   out_c_valid/ready/bits out/in/out   1/1/C_W  C toward slave
//   out_d_valid/ready/bits in/out/in    1/1/D_W  D from slave {opcode,param[1:0],size,source,sink,denied,data,corrupt}
//   in_d_valid/ready/bits  out/in/out   1/1/D_W  D toward master
//   in_e_valid/ready/bits  in/out/in    1/1/E_W  E from master {sink}
//   out_e_valid/ready/bits out/in/out   1/1/E_W  E toward slave
//   idle           out  1      1 when every queue with depth >= 1 holds 0 entries
// BEHAVIOUR
//   Reset (reset==0 at posedge):
//     - all counts and pointers go to 0; all queued out-valids go to 0; idle goes to 1.
//     - Queued entries are discarded. Reset mid-transfer drops beats; the system must reset both sides together.
//   Depth 0: valid, ready and bits are wired straight through, with zero latency; FLOW/PIPE bits are ignored.
//   Depth N >= 1:
//     - circular buffer; enq_ptr and deq_ptr are clog2(N) bits, wrapping from N-1 to 0.
//     - count is clog2(N+1) bits, range 0..N.
//     - enq fires on valid&ready; deq fires on out_valid&out_ready.
//     - Simultaneous enq and deq leaves count unchanged; both pointers advance.
//     - out_valid = count!=0; out_bits = mem[deq_ptr] (registered storage, no comb path from in_bits).
//     - Latency is 1 cycle when FLOW=0.
//     - in_ready = count!=N; with PIPE=1, in_ready = count!=N | out_ready.
//     - Full + PIPE + out_ready: enq and deq in the same cycle, and count stays N.
//     - FLOW=1 and count==0:
//         out_valid = in_valid and out_bits = in_bits.
//         If out_ready, the beat bypasses with nothing written and no count change.
//         Otherwise it is enqueued normally.
//     - Depth 1, PIPE=0: at most one beat every 2 cycles (documented, intended).
//   Handshake rules:
//     - out_valid must not drop and out_bits must not change while out_valid & !out_ready.
//     - in_ready must not depend on in_valid.
//   Multi-beat bursts are treated beat by beat; there is no burst awareness and no reordering.
//   Channel ordering: channels are independent, and no ordering between channels is imposed beyond what TileLink allows.
//   idle is combinational from the counts; it ignores depth-0 channels.
// STRUCTURE
//   tl_buffer_pkg:
//     - field-width localparams and the functions a_w(), c_w(), d_w(), e_w() giving A_W/C_W/D_W/E_W.
//     - field offset localparams for packing, and channel index constants CH_A=0, CH_C=1, CH_D=2, CH_E=3.
//   Sub-module tl_buffer_queue #(WIDTH, DEPTH, FLOW, PIPE):
//     - one generic queue, instantiated per channel inside a generate block.
//     - DEPTH==0 elaborates to wires.
//   The top does only instantiation, pass-through of depth-0 channels, and the idle reduction.
// TESTING
//   1. A_DEPTH=2, out_a_ready=0; push A beats 0x11,0x22.
//      -> in_a_ready drops after the 2nd; out_a_bits.data=0x11 held stable; idle=0.
//   2. D_DEPTH=2, FLOW/PIPE=0; stream 8 beats with out ready always high.
//      -> one beat per cycle, 1-cycle latency, order 0..7.
//      -> pointers wrap 1->0 four times; idle=1 after the drain.
//   3. A_DEPTH=1, PIPE_MASK[0]=1, queue full, out_a_ready=1.
//      -> in_a_ready=1; enq and deq happen in the same cycle; count stays 1; 100% throughput.
//   4. C_DEPTH=2, FLOW_MASK[1]=1, queue empty, out_c_ready=1, in_c_valid with data 0xAB.
//      -> out_c_valid same cycle with data 0xAB; count stays 0.
//   5. Fill D to 2 entries; drive reset=0 for 1 cycle.
//      -> next cycle in_d_valid=0, idle=1, in/out readies=1; next beat exits first, with no stale data.
//   6. E_DEPTH=0, random valid/ready for 1000 cycles.
//      -> out_e mirrors in_e combinationally every cycle (scoreboard matches all beats).

Source files
------------

// File: rtl/tl_channel_buffer_pkg.sv
// Field widths, packing offsets and channel indices shared by the TileLink channel buffer,
// its per-channel queue and anything that packs or unpacks channel beats.
package tl_buffer_pkg;

    localparam int OPCODE_W    = 3;
    localparam int A_PARAM_W   = 3;
    localparam int C_PARAM_W   = 3;
    localparam int D_PARAM_W   = 2;
    localparam int DENIED_W    = 1;
    localparam int CORRUPT_W   = 1;
    localparam int NUM_CH      = 4;

    // Every payload-bearing channel packs corrupt at bit 0 with data directly above it.
    localparam int CORRUPT_OFF = 0;
    localparam int DATA_OFF    = CORRUPT_OFF + CORRUPT_W;

    typedef enum logic [1:0] {
        CH_A = 2'd0,
        CH_C = 2'd1,
        CH_D = 2'd2,
        CH_E = 2'd3
    } tl_channel_e;

    // A: {opcode, param, size, source, address, mask, data, corrupt}
    function automatic int a_w(input int addr_w, input int data_w, input int size_w,
                               input int source_w);
        return OPCODE_W + A_PARAM_W + size_w + source_w + addr_w + data_w / 8 + data_w + CORRUPT_W;
    endfunction

    // C: {opcode, param, size, source, address, data, corrupt}
    function automatic int c_w(input int addr_w, input int data_w, input int size_w,
                               input int source_w);
        return OPCODE_W + C_PARAM_W + size_w + source_w + addr_w + data_w + CORRUPT_W;
    endfunction

    // D: {opcode, param, size, source, sink, denied, data, corrupt}
    function automatic int d_w(input int data_w, input int size_w, input int source_w,
                               input int sink_w);
        return OPCODE_W + D_PARAM_W + size_w + source_w + sink_w + DENIED_W + data_w + CORRUPT_W;
    endfunction

    // E: {sink}
    function automatic int e_w(input int sink_w);
        return sink_w;
    endfunction

    // A mask sits immediately above the data field.
    function automatic int a_mask_off(input int data_w);
        return DATA_OFF + data_w;
    endfunction

endpackage

// File: rtl/tl_channel_buffer_if.sv
// One TileLink channel handshake: valid/ready plus a packed beat of WIDTH bits.
interface tl_channel_buffer_if #(
    parameter int WIDTH = 1
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] bits;

    modport master (output valid, output bits, input ready);
    modport slave  (input valid, input bits, output ready);
endinterface

// File: rtl/tl_channel_buffer_queue.sv
// Generic single-channel elastic queue: depth 0 is a plain wire, otherwise a circular buffer
// with optional empty-queue bypass (FLOW) and ready-through-when-full (PIPE).
module tl_buffer_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter bit FLOW  = 1'b0,
    parameter bit PIPE  = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_bits,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_bits,
    output logic             empty
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clock ^ reset;
            assign deq_valid      = enq_valid;
            assign deq_bits       = enq_bits;
            assign enq_ready      = deq_ready;
            assign empty          = 1'b1;
        end else begin : g_queue
            // A single-entry queue still carries a 1-bit pointer that never leaves 0.
            localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
            localparam int CNT_W = $clog2(DEPTH + 1);
            localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
            localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

            logic [WIDTH-1:0] mem_q [DEPTH];
            logic [PTR_W-1:0] enq_ptr_q, enq_ptr_d;
            logic [PTR_W-1:0] deq_ptr_q, deq_ptr_d;
            logic [CNT_W-1:0] count_q, count_d;
            logic             is_empty, is_full, bypass, do_enq, do_deq;

            always_comb begin
                is_empty  = (count_q == '0);
                is_full   = (count_q == FULL_CNT);
                enq_ready = !is_full || (PIPE && deq_ready);
                deq_valid = !is_empty || (FLOW && enq_valid);
                deq_bits  = (FLOW && is_empty) ? enq_bits : mem_q[deq_ptr_q];
                empty     = is_empty;

                // A bypassed beat leaves storage, pointers and count untouched.
                bypass    = FLOW && is_empty && enq_valid && deq_ready;
                do_enq    = enq_valid && enq_ready && !bypass;
                do_deq    = !is_empty && deq_ready;

                enq_ptr_d = enq_ptr_q;
                deq_ptr_d = deq_ptr_q;
                count_d   = count_q;
                if (do_enq) begin
                    enq_ptr_d = (enq_ptr_q == LAST_PTR) ? '0 : enq_ptr_q + 1'b1;
                end
                if (do_deq) begin
                    deq_ptr_d = (deq_ptr_q == LAST_PTR) ? '0 : deq_ptr_q + 1'b1;
                end
                if (do_enq && !do_deq) begin
                    count_d = count_q + 1'b1;
                end else if (!do_enq && do_deq) begin
                    count_d = count_q - 1'b1;
                end
            end

            always_ff @(posedge clock) begin
                if (!reset) begin
                    enq_ptr_q <= '0;
                    deq_ptr_q <= '0;
                    count_q   <= '0;
                end else begin
                    enq_ptr_q <= enq_ptr_d;
                    deq_ptr_q <= deq_ptr_d;
                    count_q   <= count_d;
                end
            end

            // Storage is never cleared; a zero count makes any stale contents unreachable.
            always_ff @(posedge clock) begin
                if (do_enq) begin
                    mem_q[enq_ptr_q] <= enq_bits;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/tl_channel_buffer.sv
// TileLink-C buffer on the A, C, D and E channels: one independently sized queue per channel
// and an idle flag that is high when every real queue is empty.
module tl_channel_buffer
    import tl_buffer_pkg::*;
#(
    parameter int         ADDR_W    = 32,
    parameter int         DATA_W    = 64,
    parameter int         SIZE_W    = 3,
    parameter int         SOURCE_W  = 3,
    parameter int         SINK_W    = 3,
    parameter int         A_DEPTH   = 2,
    parameter int         C_DEPTH   = 2,
    parameter int         D_DEPTH   = 2,
    parameter int         E_DEPTH   = 0,
    parameter logic [3:0] FLOW_MASK = 4'b0000,
    parameter logic [3:0] PIPE_MASK = 4'b0000
) (
    input  logic                 clock,
    input  logic                 reset,
    tl_channel_buffer_if.slave   in_a,
    tl_channel_buffer_if.master  out_a,
    tl_channel_buffer_if.slave   in_c,
    tl_channel_buffer_if.master  out_c,
    tl_channel_buffer_if.slave   out_d,
    tl_channel_buffer_if.master  in_d,
    tl_channel_buffer_if.slave   in_e,
    tl_channel_buffer_if.master  out_e,
    output logic                 idle
);

    localparam int A_W = a_w(ADDR_W, DATA_W, SIZE_W, SOURCE_W);
    localparam int C_W = c_w(ADDR_W, DATA_W, SIZE_W, SOURCE_W);
    localparam int D_W = d_w(DATA_W, SIZE_W, SOURCE_W, SINK_W);
    localparam int E_W = e_w(SINK_W);

    logic [NUM_CH-1:0] ch_empty;

    // D flows slave-to-master, so its enqueue side is the out_d port.
    generate
        tl_buffer_queue #(
            .WIDTH (A_W), .DEPTH (A_DEPTH), .FLOW (FLOW_MASK[CH_A]), .PIPE (PIPE_MASK[CH_A])
        ) u_queue_a (
            .clock     (clock),
            .reset     (reset),
            .enq_valid (in_a.valid),
            .enq_ready (in_a.ready),
            .enq_bits  (in_a.bits),
            .deq_valid (out_a.valid),
            .deq_ready (out_a.ready),
            .deq_bits  (out_a.bits),
            .empty     (ch_empty[CH_A])
        );

        tl_buffer_queue #(
            .WIDTH (C_W), .DEPTH (C_DEPTH), .FLOW (FLOW_MASK[CH_C]), .PIPE (PIPE_MASK[CH_C])
        ) u_queue_c (
            .clock     (clock),
            .reset     (reset),
            .enq_valid (in_c.valid),
            .enq_ready (in_c.ready),
            .enq_bits  (in_c.bits),
            .deq_valid (out_c.valid),
            .deq_ready (out_c.ready),
            .deq_bits  (out_c.bits),
            .empty     (ch_empty[CH_C])
        );

        tl_buffer_queue #(
            .WIDTH (D_W), .DEPTH (D_DEPTH), .FLOW (FLOW_MASK[CH_D]), .PIPE (PIPE_MASK[CH_D])
        ) u_queue_d (
            .clock     (clock),
            .reset     (reset),
            .enq_valid (out_d.valid),
            .enq_ready (out_d.ready),
            .enq_bits  (out_d.bits),
            .deq_valid (in_d.valid),
            .deq_ready (in_d.ready),
            .deq_bits  (in_d.bits),
            .empty     (ch_empty[CH_D])
        );

        tl_buffer_queue #(
            .WIDTH (E_W), .DEPTH (E_DEPTH), .FLOW (FLOW_MASK[CH_E]), .PIPE (PIPE_MASK[CH_E])
        ) u_queue_e (
            .clock     (clock),
            .reset     (reset),
            .enq_valid (in_e.valid),
            .enq_ready (in_e.ready),
            .enq_bits  (in_e.bits),
            .deq_valid (out_e.valid),
            .deq_ready (out_e.ready),
            .deq_bits  (out_e.bits),
            .empty     (ch_empty[CH_E])
        );
    endgenerate

    // Depth-0 channels report empty permanently, so they never hold idle low.
    assign idle = &ch_empty;

endmodule
